// File: rtl/stream_mux_rr_if.sv
// Stream mux bus: N input channels, one registered output.
// Ports: in_data/in_valid/in_ready, sel, mode, out_data/out_valid/out_ready/out_ch.
interface stream_mux_rr_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2
) ();
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SEL_W-1:0]   sel;
  logic               mode;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   out_ch;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-to-1 stream mux, fixed-select or round-robin, 1-deep output register.
// Ports: clk, rst (sync, active-high), bus (stream_mux_rr_if.slave).
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input logic             clk,
  input logic             rst,
  stream_mux_rr_if.slave  bus
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             slot_free;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt;
  logic [N-1:0]     in_ready_c;

  assign slot_free = !out_valid_q || bus.out_ready;

  // Round-robin scans upward from rr_ptr+1 with wrap;
  // fixed mode grants only an in-range, valid sel.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt     = '0;
    if (bus.mode) begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(rr_ptr_q) + k) % N;
        if (!gnt_vld && bus.in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt     = SEL_W'(idx);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (int'(bus.sel) == i) begin
          gnt_vld = bus.in_valid[i];
          gnt     = SEL_W'(i);
        end
      end
    end
  end

  // rst gates in_ready so no beat is accepted during reset.
  always_comb begin
    in_ready_c = '0;
    for (int i = 0; i < N; i++) begin
      in_ready_c[i] = gnt_vld && slot_free && !rst
                      && (int'(gnt) == i);
    end
  end

  assign bus.in_ready = in_ready_c;

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (slot_free) begin
      if (gnt_vld) begin
        out_data_d  = bus.in_data[int'(gnt)*WIDTH +: WIDTH];
        out_ch_d    = gnt;
        out_valid_d = 1'b1;
        if (bus.mode) begin
          rr_ptr_d = gnt;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // rr_ptr resets to N-1 so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= SEL_W'(N - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr (N=4, N=8 wide, N=3 instances).
// Expected beats are queued by stimulus, popped by output monitors.
module tb_stream_mux_rr;

  typedef struct {
    logic [3:0]  ch;
    logic [15:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t qm[$];
  exp_t qw[$];
  exp_t em, ew;

  always #5 clk = ~clk;

  stream_mux_rr_if #(.WIDTH(8), .N(4), .SEL_W(2)) m ();
  stream_mux_rr_if #(.WIDTH(16), .N(8), .SEL_W(3)) w ();
  stream_mux_rr_if #(.WIDTH(8), .N(3), .SEL_W(2)) t ();

  stream_mux_rr #(.WIDTH(8), .N(4), .SEL_W(2)) u_m (
    .clk(clk), .rst(rst), .bus(m.slave)
  );
  stream_mux_rr #(.WIDTH(16), .N(8), .SEL_W(3)) u_w (
    .clk(clk), .rst(rst), .bus(w.slave)
  );
  stream_mux_rr #(.WIDTH(8), .N(3), .SEL_W(2)) u_t (
    .clk(clk), .rst(rst), .bus(t.slave)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(int ch, int d);
    exp_t e;
    e.ch = 4'(ch);
    e.d  = 16'(d);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && m.out_valid && m.out_ready) begin
      n_cmp++;
      if (qm.size() == 0) begin
        n_bad++;
        $display("FAIL m_beat unexpected ch=%0d data=%h required none",
                 m.out_ch, m.out_data);
      end else begin
        em = qm.pop_front();
        if (m.out_ch !== em.ch[1:0] || m.out_data !== em.d[7:0]) begin
          n_bad++;
          $display("FAIL m_beat actual ch=%0d data=%h required ch=%0d data=%h",
                   m.out_ch, m.out_data, em.ch, em.d[7:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && w.out_valid && w.out_ready) begin
      n_cmp++;
      if (qw.size() == 0) begin
        n_bad++;
        $display("FAIL w_beat unexpected ch=%0d data=%h required none",
                 w.out_ch, w.out_data);
      end else begin
        ew = qw.pop_front();
        if (w.out_ch !== ew.ch[2:0] || w.out_data !== ew.d) begin
          n_bad++;
          $display("FAIL w_beat actual ch=%0d data=%h required ch=%0d data=%h",
                   w.out_ch, w.out_data, ew.ch, ew.d);
        end
      end
    end
  end

  initial begin
    m.in_data = '0; m.in_valid = '0; m.sel = '0;
    m.mode = 1'b0; m.out_ready = 1'b1;
    w.in_data = '0; w.in_valid = '0; w.sel = '0;
    w.mode = 1'b0; w.out_ready = 1'b1;
    t.in_data = '0; t.in_valid = '0; t.sel = '0;
    t.mode = 1'b0; t.out_ready = 1'b1;

    // reset
    rst = 1'b1;
    step(); step();
    m.in_valid = 4'hF;
    #1 chk("rst_in_ready", 32'(m.in_ready), 0);
    m.in_valid = 4'h0;
    step();
    chk("rst_out_valid", 32'(m.out_valid), 0);
    chk("rst_out_data", 32'(m.out_data), 0);
    chk("rst_out_ch", 32'(m.out_ch), 0);
    rst = 1'b0;

    // fixed select ch2
    m.mode = 1'b0; m.sel = 2'd2;
    m.in_data = 32'h00A5_0000; m.in_valid = 4'b0100;
    #1 chk("fix_in_ready", 32'(m.in_ready), 32'h4);
    qm.push_back(mk(2, 'hA5));
    step();
    m.in_valid = 4'h0;
    chk("fix_out_valid", 32'(m.out_valid), 1);
    chk("fix_out_data", 32'(m.out_data), 32'hA5);
    step();
    chk("fix_idle_valid", 32'(m.out_valid), 0);
    chk("fix_idle_hold", 32'(m.out_data), 32'hA5);

    // round-robin over all four
    m.mode = 1'b1;
    m.in_data = 32'h1312_1110; m.in_valid = 4'hF;
    qm.push_back(mk(0, 'h10)); qm.push_back(mk(1, 'h11));
    qm.push_back(mk(2, 'h12)); qm.push_back(mk(3, 'h13));
    qm.push_back(mk(0, 'h10));
    #1 chk("rr_first_ready", 32'(m.in_ready), 32'h1);
    repeat (5) step();
    m.in_valid = 4'h0;
    step();
    chk("rr_drain_valid", 32'(m.out_valid), 0);
    chk("rr_no_bubble", 32'(qm.size()), 0);

    // backpressure hold then drain+load same cycle
    m.in_data = 32'h2300_2100; m.in_valid = 4'b1010;
    m.out_ready = 1'b0;
    qm.push_back(mk(1, 'h21));
    #1 chk("bp_first_ready", 32'(m.in_ready), 32'h2);
    step();
    repeat (3) begin
      #1 chk("bp_ready", 32'(m.in_ready), 0);
      chk("bp_data", 32'(m.out_data), 32'h21);
      chk("bp_ch", 32'(m.out_ch), 1);
      step();
    end
    m.out_ready = 1'b1;
    qm.push_back(mk(3, 'h23));
    #1 chk("bp_ready_ch3", 32'(m.in_ready), 32'h8);
    step();
    m.in_valid = 4'h0;
    chk("bp_load_ch", 32'(m.out_ch), 3);
    chk("bp_load_data", 32'(m.out_data), 32'h23);
    step();
    chk("bp_empty", 32'(qm.size()), 0);

    // fixed sel=3 with ch3 idle: no grant
    m.mode = 1'b0; m.sel = 2'd3; m.in_valid = 4'b0111;
    #1 chk("sel3_ready", 32'(m.in_ready), 0);
    step();
    chk("sel3_valid", 32'(m.out_valid), 0);

    // mode/sel change must not disturb a held beat
    m.sel = 2'd0; m.in_valid = 4'b0001;
    m.in_data = 32'h0000_0044; m.out_ready = 1'b0;
    qm.push_back(mk(0, 'h44));
    step();
    m.mode = 1'b1; m.sel = 2'd1; m.in_valid = 4'b0010;
    #1 chk("chg_ready", 32'(m.in_ready), 0);
    step();
    chk("chg_data", 32'(m.out_data), 32'h44);
    chk("chg_ch", 32'(m.out_ch), 0);
    m.in_valid = 4'h0; m.out_ready = 1'b1;
    step();
    chk("chg_drain", 32'(m.out_valid), 0);

    // reset while a beat is stalled
    m.mode = 1'b1; m.out_ready = 1'b0;
    m.in_data = 32'h0000_0055; m.in_valid = 4'b0001;
    step();
    m.in_valid = 4'h0;
    chk("mid_loaded", 32'(m.out_valid), 1);
    rst = 1'b1; m.in_valid = 4'hF;
    #1 chk("mid_rst_ready", 32'(m.in_ready), 0);
    step();
    chk("mid_rst_valid", 32'(m.out_valid), 0);
    chk("mid_rst_data", 32'(m.out_data), 0);
    chk("mid_rst_ch", 32'(m.out_ch), 0);
    rst = 1'b0; m.out_ready = 1'b1;
    m.in_data = 32'h3332_3130; m.in_valid = 4'hF;
    qm.push_back(mk(0, 'h30));
    #1 chk("post_rst_ready", 32'(m.in_ready), 32'h1);
    step();
    m.in_valid = 4'h0;
    step();
    chk("post_rst_empty", 32'(qm.size()), 0);

    // wide instance: channels 0 and 7 alternate
    w.mode = 1'b1; w.out_ready = 1'b1;
    w.in_data = '0;
    w.in_data[15:0]    = 16'h1000;
    w.in_data[127:112] = 16'h7007;
    w.in_valid = 8'h81;
    qw.push_back(mk(0, 'h1000)); qw.push_back(mk(7, 'h7007));
    qw.push_back(mk(0, 'h1000)); qw.push_back(mk(7, 'h7007));
    #1 chk("w_first_ready", 32'(w.in_ready), 32'h01);
    repeat (4) step();
    w.in_valid = 8'h00;
    step();
    chk("w_drain_valid", 32'(w.out_valid), 0);
    chk("w_empty", 32'(qw.size()), 0);

    // N=3: sel=3 never grants, sel=2 does
    t.mode = 1'b0; t.sel = 2'd3; t.in_valid = 3'b111;
    repeat (3) begin
      #1 chk("n3_sel3_ready", 32'(t.in_ready), 0);
      step();
      chk("n3_sel3_valid", 32'(t.out_valid), 0);
    end
    t.sel = 2'd2;
    #1 chk("n3_sel2_ready", 32'(t.in_ready), 32'h4);
    t.in_valid = 3'b000;

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
